pic_irq_core: RTL and testbench

//  Parametrised, clocked successor of the 8259-style interrupt block: IRR, ISR, priority resolver, INTA/EOI handshake.

---
 rtl/pic_irq_core.sv | 142 ++++++++++++++
 tb/tb_pic_irq_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_irq_core.sv
// 8259-style interrupt core: request/in-service registers, rotating priority resolver, INTA/EOI handshake.
// Define PIC_AUTO_EOI_EN to add the aeoi input (acknowledge without setting the in-service bit).
module pic_irq_core #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] ir,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               level_mode,
    input  logic               rotate_mode,
    input  logic               inta,
    input  logic               eoi,
    input  logic               seoi,
    input  logic [IDX_W-1:0]   seoi_idx,
`ifdef PIC_AUTO_EOI_EN
    input  logic               aeoi,
`endif
    output logic               int_out,
    output logic               vec_valid,
    output logic [IDX_W-1:0]   vec_idx,
    output logic [NUM_IRQ-1:0] irr_q,
    output logic [NUM_IRQ-1:0] isr_q
);

    localparam logic [IDX_W:0]   N_W      = (IDX_W+1)'(NUM_IRQ);
    localparam logic [IDX_W-1:0] SPUR_IDX = IDX_W'(NUM_IRQ - 1);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] ir_prev_q;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_IRQ-1:0] irr_d, isr_d;
    logic [IDX_W:0]     pend_rank, isr_rank;
    logic [IDX_W-1:0]   win_line, eoi_line;
    logic               qual, accept, aeoi_on, int_d;

`ifdef PIC_AUTO_EOI_EN
    assign aeoi_on = aeoi;
`else
    assign aeoi_on = 1'b0;
`endif

    // Rank of the first set bit counting from the pointer; N_W means none set.
    function automatic logic [IDX_W:0] pick_rank(input logic [NUM_IRQ-1:0] v,
                                                 input logic [IDX_W-1:0]   p);
        logic [2*NUM_IRQ-1:0] dbl;
        logic [NUM_IRQ-1:0]   rot, tmp;
        dbl       = {v, v} >> p;
        rot       = dbl[NUM_IRQ-1:0];
        pick_rank = N_W;
        for (int o = NUM_IRQ - 1; o >= 0; o--) begin
            tmp = rot >> o;
            if (tmp[0]) pick_rank = (IDX_W+1)'(o);
        end
    endfunction

    function automatic logic [IDX_W-1:0] rank_to_line(input logic [IDX_W:0]   r,
                                                      input logic [IDX_W-1:0] p);
        logic [IDX_W:0] s;
        s = {1'b0, p} + r;
        if (s >= N_W) s = s - N_W;
        return s[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_IRQ'(1'b1) << idx;
    endfunction

    always_comb begin
        pend_rank = pick_rank(irr_q & ~imr, ptr_q);
        isr_rank  = pick_rank(isr_q, ptr_q);
        win_line  = rank_to_line(pend_rank, ptr_q);
        eoi_line  = rank_to_line(isr_rank, ptr_q);
        qual      = pend_rank < isr_rank;
        accept    = inta && (state_q != ACK);
    end

    always_comb begin
        state_d = state_q;
        int_d   = qual && !accept;
        case (state_q)
            IDLE:    state_d = accept ? ACK : (qual ? REQ : IDLE);
            REQ:     state_d = accept ? ACK : (qual ? REQ : IDLE);
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (level_mode) begin
            irr_d = ir;
        end else begin
            irr_d = irr_q;
            if (accept && qual) irr_d = irr_d & ~onehot(win_line);
            irr_d = irr_d | (ir & ~ir_prev_q);
        end

        isr_d = isr_q;
        ptr_d = ptr_q;
        // Specific EOI shadows a simultaneous non-specific EOI entirely.
        if (seoi) begin
            if ({1'b0, seoi_idx} < N_W) isr_d = isr_d & ~onehot(seoi_idx);
        end else if (eoi && (isr_q != '0)) begin
            isr_d = isr_d & ~onehot(eoi_line);
            if (rotate_mode) ptr_d = rank_to_line((IDX_W+1)'(1), eoi_line);
        end
        if (accept && qual) begin
            if (aeoi_on) begin
                if (rotate_mode) ptr_d = rank_to_line((IDX_W+1)'(1), win_line);
            end else begin
                isr_d = isr_d | onehot(win_line);
            end
        end
        if (!rotate_mode) ptr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            irr_q     <= '0;
            isr_q     <= '0;
            ir_prev_q <= '0;
            ptr_q     <= '0;
            int_out   <= 1'b0;
            vec_valid <= 1'b0;
            vec_idx   <= '0;
        end else begin
            state_q   <= state_d;
            irr_q     <= irr_d;
            isr_q     <= isr_d;
            ir_prev_q <= ir;
            ptr_q     <= ptr_d;
            int_out   <= int_d;
            vec_valid <= accept;
            if (accept) vec_idx <= qual ? win_line : SPUR_IDX;
        end
    end

endmodule

// File: tb/tb_pic_irq_core.sv
// Bench for pic_irq_core: directed scenarios plus randomized traffic against a behavioural model.
module tb_pic_irq_core;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         reset;
    logic [N-1:0] ir, imr;
    logic         level_mode, rotate_mode, inta, eoi, seoi;
    logic [W-1:0] seoi_idx;
    logic         int_out, vec_valid;
    logic [W-1:0] vec_idx;
    logic [N-1:0] irr_q, isr_q;

    pic_irq_core #(.NUM_IRQ(N), .IDX_W(W)) dut (
        .clk(clk), .reset(reset), .ir(ir), .imr(imr), .level_mode(level_mode),
        .rotate_mode(rotate_mode), .inta(inta), .eoi(eoi), .seoi(seoi), .seoi_idx(seoi_idx),
        .int_out(int_out), .vec_valid(vec_valid), .vec_idx(vec_idx), .irr_q(irr_q), .isr_q(isr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // Model state (m_*) and its next value (n_*)
    logic [N-1:0] m_irr, m_isr, m_prev, n_irr, n_isr, n_prev;
    int           m_ptr, n_ptr;
    bit           m_ack, n_ack;
    logic         m_int, m_vv, n_int, n_vv;
    logic [W-1:0] m_vidx, n_vidx;

    function automatic int top_line(input logic [N-1:0] v, input int p);
        logic [N-1:0] tmp;
        for (int o = 0; o < N; o++) begin
            tmp = v >> ((p + o) % N);
            if (tmp[0]) return (p + o) % N;
        end
        return -1;
    endfunction

    function automatic int rank_of(input int line, input int p);
        return (line - p + N) % N;
    endfunction

    task automatic model_next();
        logic [N-1:0] pend, one_w, one_h;
        int w, h;
        bit qual, acc;
        if (reset) begin
            n_irr = '0; n_isr = '0; n_prev = '0; n_ptr = 0; n_ack = 0;
            n_int = 1'b0; n_vv = 1'b0; n_vidx = '0;
            return;
        end
        pend  = m_irr & ~imr;
        w     = top_line(pend, m_ptr);
        h     = top_line(m_isr, m_ptr);
        qual  = (w >= 0) && ((h < 0) || (rank_of(w, m_ptr) < rank_of(h, m_ptr)));
        acc   = inta && !m_ack;
        one_w = (w >= 0) ? (N'(1) << w) : '0;
        one_h = (h >= 0) ? (N'(1) << h) : '0;
        if (level_mode) n_irr = ir;
        else            n_irr = (m_irr & ~((acc && qual) ? one_w : '0)) | (ir & ~m_prev);
        n_isr = m_isr;
        n_ptr = m_ptr;
        if (seoi) begin
            if (int'(seoi_idx) < N) n_isr = n_isr & ~(N'(1) << seoi_idx);
        end else if (eoi && h >= 0) begin
            n_isr = n_isr & ~one_h;
            if (rotate_mode) n_ptr = (h + 1) % N;
        end
        if (acc && qual) n_isr = n_isr | one_w;
        if (!rotate_mode) n_ptr = 0;
        n_prev = ir;
        n_ack  = acc;
        n_int  = qual && !acc;
        n_vv   = acc;
        n_vidx = acc ? (qual ? W'(w) : W'(N - 1)) : m_vidx;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        m_irr = n_irr; m_isr = n_isr; m_prev = n_prev; m_ptr = n_ptr; m_ack = n_ack;
        m_int = n_int; m_vv = n_vv; m_vidx = n_vidx;
        chk("model_int_out",   32'(int_out),   32'(m_int));
        chk("model_vec_valid", 32'(vec_valid), 32'(m_vv));
        chk("model_vec_idx",   32'(vec_idx),   32'(m_vidx));
        chk("model_irr_q",     32'(irr_q),     32'(m_irr));
        chk("model_isr_q",     32'(isr_q),     32'(m_isr));
    endtask

    task automatic do_reset();
        reset = 1'b1; ir = '0; inta = 1'b0; eoi = 1'b0; seoi = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ir = '0; imr = '0; level_mode = 1'b0; rotate_mode = 1'b0;
        inta = 1'b0; eoi = 1'b0; seoi = 1'b0; seoi_idx = '0;
        m_irr = '0; m_isr = '0; m_prev = '0; m_ptr = 0; m_ack = 0;
        m_int = 1'b0; m_vv = 1'b0; m_vidx = '0;

        // Reset values
        do_reset();
        chk("rst_int_out", 32'(int_out), 32'h0);
        chk("rst_vec_valid", 32'(vec_valid), 32'h0);
        chk("rst_vec_idx", 32'(vec_idx), 32'h0);
        chk("rst_irr", 32'(irr_q), 32'h0);
        chk("rst_isr", 32'(isr_q), 32'h0);

        // Edge-triggered, fixed priority, then nesting
        ir = 8'h24; step();
        chk("edge_irr", 32'(irr_q), 32'h24);
        step();
        chk("edge_int_out", 32'(int_out), 32'h1);
        inta = 1'b1; step(); inta = 1'b0;
        chk("edge_vec_valid", 32'(vec_valid), 32'h1);
        chk("edge_vec_idx", 32'(vec_idx), 32'h2);
        chk("edge_isr", 32'(isr_q), 32'h04);
        chk("edge_irr_after", 32'(irr_q), 32'h20);
        chk("ack_int_low", 32'(int_out), 32'h0);
        step();
        chk("nest_blocked", 32'(int_out), 32'h0);
        ir = 8'h26; step(); step();
        chk("nest_int_out", 32'(int_out), 32'h1);
        inta = 1'b1; step(); inta = 1'b0;
        chk("nest_vec_idx", 32'(vec_idx), 32'h1);
        chk("nest_isr", 32'(isr_q), 32'h06);

        // Rotation after EOI on line 3
        rotate_mode = 1'b1;
        do_reset();
        ir = 8'h08; step(); step();
        inta = 1'b1; step(); inta = 1'b0;
        chk("rot_first_idx", 32'(vec_idx), 32'h3);
        ir = '0; eoi = 1'b1; step(); eoi = 1'b0;
        chk("rot_eoi_isr", 32'(isr_q), 32'h0);
        ir = 8'h09; step(); step();
        chk("rot_int_out", 32'(int_out), 32'h1);
        inta = 1'b1; step(); inta = 1'b0;
        chk("rot_vec_idx", 32'(vec_idx), 32'h0);

        // Spurious acknowledge in level mode
        rotate_mode = 1'b0; level_mode = 1'b1;
        do_reset();
        ir = 8'h40; step();
        ir = '0; step(); step();
        inta = 1'b1; step(); inta = 1'b0;
        chk("spur_vec_valid", 32'(vec_valid), 32'h1);
        chk("spur_vec_idx", 32'(vec_idx), 32'h7);
        chk("spur_isr", 32'(isr_q), 32'h0);
        level_mode = 1'b0;

        // Specific EOI wins over simultaneous non-specific EOI
        do_reset();
        ir = 8'h10; step(); step();
        inta = 1'b1; step(); inta = 1'b0;
        ir = 8'h12; step(); step();
        inta = 1'b1; step(); inta = 1'b0;
        chk("seoi_isr_before", 32'(isr_q), 32'h12);
        seoi = 1'b1; seoi_idx = 3'd4; eoi = 1'b1; step(); seoi = 1'b0; eoi = 1'b0;
        chk("seoi_isr_after", 32'(isr_q), 32'h02);

        // Reset during the ACK cycle
        do_reset();
        ir = 8'h01; step(); step();
        inta = 1'b1; step(); inta = 1'b0;
        chk("rack_vec_valid_pre", 32'(vec_valid), 32'h1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rack_vec_valid", 32'(vec_valid), 32'h0);
        chk("rack_irr", 32'(irr_q), 32'h0);
        chk("rack_isr", 32'(isr_q), 32'h0);
        chk("rack_int_out", 32'(int_out), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) ir = N'($urandom) & N'($urandom);
            imr      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            inta     = ($urandom_range(0, 3) == 0);
            eoi      = ($urandom_range(0, 5) == 0);
            seoi     = ($urandom_range(0, 7) == 0);
            seoi_idx = W'($urandom);
            if ($urandom_range(0, 49) == 0) level_mode  = ~level_mode;
            if ($urandom_range(0, 29) == 0) rotate_mode = ~rotate_mode;
            step();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
